bus_master: RTL

Initiator for the shared 8-bit bidirectional register bus. Accepts single read/write requests from a host-side handshake and sequences the bus as SETUP, STROBE/WAIT, then completion: register select, write strobe `Rw` and tri-state data drive. It is the far end of the bus from the register targets, which latch the bus on `clk` while `Rw=1` and drive it when selected with `Rw=0`. It captures read data and returns it to the host with a one-cycle acknowledge.

---
 rtl/bus_master_pkg.sv | 16 +
 rtl/bus_master_bus_drv.sv | 14 +
 rtl/bus_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bus_master_pkg.sv
// Shared types and constants for the register-bus initiator.
package bus_master_pkg;

  typedef enum logic [2:0] {
    BM_IDLE    = 3'd0,
    BM_SETUP   = 3'd1,
    BM_STROBE  = 3'd2,
    BM_RECOVER = 3'd3,
    BM_WAIT    = 3'd4,
    BM_DONE    = 3'd5
  } bm_state_t;

  localparam int BM_WAIT_MAX = 15;
  localparam int BM_CNT_W    = 4;

endpackage

// File: rtl/bus_master_bus_drv.sv
// Tri-state pad model for a bus agent: registered drive in, resolved bus value out.
module bus_drv #(
  parameter int DW = 8
) (
  input  logic          oe,
  input  logic [DW-1:0] dout,
  inout  wire  [DW-1:0] bus,
  output logic [DW-1:0] din
);

  assign bus = oe ? dout : {DW{1'bz}};
  assign din = bus;

endmodule

// File: rtl/bus_master.sv
// Register-bus initiator: sequences SETUP, STROBE/WAIT and DONE for single
// host read/write requests; every output is registered from the next state.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int NREG     = 4,
  parameter int AW       = 2,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic            clk,
  input  logic            Rs,
  input  logic            req,
  input  logic            wr,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic            busy,
  output logic            ack,
  output logic            err,
  output logic [DW-1:0]   rdata,
  output logic [NREG-1:0] sel,
  output logic            Rw,
  inout  wire  [DW-1:0]   bus
);

  localparam int WAIT_EFF = (WAIT_CYC > BM_WAIT_MAX) ? BM_WAIT_MAX :
                            ((WAIT_CYC < 1) ? 1 : WAIT_CYC);
  localparam logic [BM_CNT_W-1:0] WAIT_LAST = BM_CNT_W'(WAIT_EFF - 1);

  bm_state_t             state_r, state_nxt_s;
  logic [BM_CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic                  wr_r, wr_nxt_s;
  logic [AW-1:0]         addr_r, addr_nxt_s;
  logic [DW-1:0]         wdata_r, wdata_nxt_s;
  logic                  err_nxt_s;
  logic                  oe_r, oe_nxt_s;
  logic [DW-1:0]         dout_r;
  logic [DW-1:0]         din_s;
  logic [NREG-1:0]       sel_nxt_s;
  logic                  sel_act_s, drv_phase_s;
  logic [31:0]           addr_ext_s;
  logic                  addr_bad_s;

  assign addr_ext_s = 32'(addr);
  assign addr_bad_s = (addr_ext_s >= 32'(NREG));

  // Next-state, transaction latch and wait-counter decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    wr_nxt_s    = wr_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      BM_IDLE: begin
        if (req) begin
          wr_nxt_s    = wr;
          addr_nxt_s  = addr;
          wdata_nxt_s = wdata;
          if (addr_bad_s) begin
            state_nxt_s = BM_DONE;
            err_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = BM_SETUP;
          end
        end else begin
          state_nxt_s = BM_IDLE;
        end
      end
      BM_SETUP: begin
        if (wr_r) begin
          state_nxt_s = BM_STROBE;
        end else begin
          state_nxt_s = BM_WAIT;
          cnt_nxt_s   = {BM_CNT_W{1'b0}};
        end
      end
      BM_STROBE:  state_nxt_s = BM_RECOVER;
      BM_RECOVER: state_nxt_s = BM_DONE;
      BM_WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          state_nxt_s = BM_DONE;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
      end
      BM_DONE: state_nxt_s = BM_IDLE;
      default: state_nxt_s = BM_IDLE;
    endcase
  end

  // Bus-facing values for the state being entered, so they register in step.
  always_comb begin
    drv_phase_s = (state_nxt_s == BM_SETUP) || (state_nxt_s == BM_STROBE) ||
                  (state_nxt_s == BM_RECOVER);
    sel_act_s   = drv_phase_s || (state_nxt_s == BM_WAIT);
    sel_nxt_s   = sel_act_s ? ({{(NREG-1){1'b0}}, 1'b1} << addr_nxt_s) : {NREG{1'b0}};
    oe_nxt_s    = wr_nxt_s && drv_phase_s;
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge Rs) begin
    if (!Rs) begin
      state_r <= BM_IDLE;
      cnt_r   <= {BM_CNT_W{1'b0}};
      wr_r    <= 1'b0;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
      oe_r    <= 1'b0;
      dout_r  <= {DW{1'b0}};
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      sel     <= {NREG{1'b0}};
      Rw      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      wr_r    <= wr_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
      oe_r    <= oe_nxt_s;
      dout_r  <= wdata_nxt_s;
      busy    <= (state_nxt_s != BM_IDLE);
      ack     <= (state_nxt_s == BM_DONE);
      err     <= err_nxt_s;
      sel     <= sel_nxt_s;
      Rw      <= (state_nxt_s == BM_STROBE);
    end
  end

  // Read capture at the edge that closes the final wait cycle.
  always_ff @(posedge clk or negedge Rs) begin
    if (!Rs) begin
      rdata <= {DW{1'b0}};
    end else if ((state_r == BM_WAIT) && (cnt_r == WAIT_LAST)) begin
      rdata <= din_s;
    end else begin
      rdata <= rdata;
    end
  end

  bus_drv #(.DW(DW)) u_drv (
    .oe   (oe_r),
    .dout (dout_r),
    .bus  (bus),
    .din  (din_s)
  );

endmodule
